// File: rtl/sseg_pkg.sv
// sseg_pkg -- shared constants for the seven-segment scan controller.
//
// Contents:
//   SSEG_OFF  : all segments dark (outputs are active-low)
//   NIB_W     : width of one hex digit nibble
//   BRIGHT_W  : width of the brightness level
//   SEG_CODE  : 16-entry {a..g} active-low code table, indexed by nibble
package sseg_pkg;

    localparam logic [7:0] SSEG_OFF = 8'hFF;
    localparam int         NIB_W    = 4;
    localparam int         BRIGHT_W = 3;

    // Active-low {a,b,c,d,e,f,g}; a 0 bit lights the segment.
    localparam logic [6:0] SEG_CODE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage

// File: rtl/Hex2Sseg.sv
// Hex2Sseg -- combinational nibble + decimal point to segment pattern.
//
// Ports:
//   nib  in  4  hex value to show
//   dp   in  1  decimal point, active-high
//   sseg out 8  {dp,a..g}, active-low
module Hex2Sseg
    import sseg_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    input  logic             dp,
    output logic [7:0]       sseg
);

    assign sseg = {~dp, SEG_CODE[nib]};

endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl -- multiplexed seven-segment display scanner with
// frame-synchronous shadow load and PWM-style brightness.
//
// Each digit owns a slot of PRESCALE cycles; a frame is N_DIG slots. The
// first cycle of every slot is always dark so the previous digit's segments
// never ghost onto the next anode. Within a slot the digit is lit for
// slot_cnt in [1, (bright+1)*PRESCALE/8).
//
// Loading: load is a single-cycle strobe with no back-pressure. It copies
// hex_in/dp_in/blank_in/bright into a shadow and raises pending. The shadow
// is committed to the displayed (active) set only at a frame boundary, so a
// frame never shows a mix of old and new values. A load landing on the
// boundary cycle itself goes to the shadow and waits for the next boundary.
//
// Ports:
//   clk        in   1        system clock, rising edge
//   reset_n    in   1        asynchronous active-low reset
//   hex_in     in   4*N_DIG  nibble per digit, digit 0 = hex_in[3:0]
//   dp_in      in   N_DIG    decimal point per digit, active-high
//   blank_in   in   N_DIG    force digit dark, active-high
//   bright     in   3        brightness 0 (dimmest) .. 7 (full)
//   load       in   1        capture strobe into shadow
//   pending    out  1        shadow not yet committed
//   frame_tick out  1        high on the last cycle of each frame
//   an         out  N_DIG    digit enables, active-low (registered)
//   sseg       out  8        {dp,a..g}, active-low (registered)
//
// Build option: define SSEG_LZ_BLANK_EN to suppress leading zero digits
// (never digit 0, never a digit showing its decimal point).
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int N_DIG    = 3,
    parameter int PRESCALE = 12000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NIB_W*N_DIG-1:0]   hex_in,
    input  logic [N_DIG-1:0]         dp_in,
    input  logic [N_DIG-1:0]         blank_in,
    input  logic [BRIGHT_W-1:0]      bright,
    input  logic                     load,
    output logic                     pending,
    output logic                     frame_tick,
    output logic [N_DIG-1:0]         an,
    output logic [7:0]               sseg
);

    localparam int              CW        = $clog2(PRESCALE);
    localparam int              DW        = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int              STEP      = PRESCALE / 8;
    localparam logic [CW-1:0]   SLOT_LAST = CW'(PRESCALE - 1);
    localparam logic [DW-1:0]   DIG_LAST  = DW'(N_DIG - 1);

    logic [CW-1:0]            slot_cnt;
    logic [DW-1:0]            dig;
    logic                     frame_end;

    logic [NIB_W*N_DIG-1:0]   sh_hex,   act_hex;
    logic [N_DIG-1:0]         sh_dp,    act_dp;
    logic [N_DIG-1:0]         sh_blank, act_blank;
    logic [BRIGHT_W-1:0]      sh_bright, act_bright;

    logic [NIB_W-1:0]         sel_nib;
    logic                     sel_dp;
    logic                     sel_blank;
    logic [N_DIG-1:0]         lz_blank;
    logic [31:0]              lit_lim;
    logic                     lit;
    logic [7:0]               dec_sseg;

    // ---------------- scan timing ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt <= '0;
            dig      <= '0;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            dig      <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    assign frame_end  = (slot_cnt == SLOT_LAST) && (dig == DIG_LAST);
    assign frame_tick = frame_end;

    // ---------------- shadow / active registers ----------------
    // Commit uses the shadow as it stood before this edge, so a load on the
    // boundary cycle is held for the following frame and keeps pending set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_hex     <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            sh_bright  <= '0;
            act_hex    <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
            act_bright <= '0;
            pending    <= 1'b0;
        end else begin
            if (frame_end && pending) begin
                act_hex    <= sh_hex;
                act_dp     <= sh_dp;
                act_blank  <= sh_blank;
                act_bright <= sh_bright;
            end
            if (load) begin
                sh_hex    <= hex_in;
                sh_dp     <= dp_in;
                sh_blank  <= blank_in;
                sh_bright <= bright;
            end
            pending <= load | (pending & ~frame_end);
        end
    end

    // ---------------- leading-zero suppression ----------------
`ifdef SSEG_LZ_BLANK_EN
    logic zero_above;
    // Walk down from the top digit; suppression stops at the first digit
    // that is nonzero or shows its decimal point.
    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int i = N_DIG - 1; i >= 1; i--) begin
            zero_above  = zero_above & (act_hex[i*NIB_W +: NIB_W] == '0) & ~act_dp[i];
            lz_blank[i] = zero_above;
        end
    end
`else
    assign lz_blank = '0;
`endif

    // ---------------- digit select ----------------
    always_comb begin
        sel_nib   = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b1;
        for (int i = 0; i < N_DIG; i++) begin
            if (dig == DW'(i)) begin
                sel_nib   = act_hex[i*NIB_W +: NIB_W];
                sel_dp    = act_dp[i];
                sel_blank = act_blank[i] | lz_blank[i];
            end
        end
    end

    Hex2Sseg u_hex2sseg (
        .nib  (sel_nib),
        .dp   (sel_dp),
        .sseg (dec_sseg)
    );

    // slot_cnt == 0 is the dead cycle between digits.
    assign lit_lim = (32'(act_bright) + 32'd1) * 32'(STEP);
    assign lit     = (slot_cnt != '0) && (32'(slot_cnt) < lit_lim) && !sel_blank;

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an   <= '1;
            sseg <= SSEG_OFF;
        end else if (lit) begin
            an   <= ~(N_DIG'(1) << dig);
            sseg <= dec_sseg;
        end else begin
            an   <= '1;
            sseg <= SSEG_OFF;
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl -- self-checking bench for sseg_scan_ctrl
// (N_DIG=3, PRESCALE=16). A frame-arithmetic reference model runs beside
// the DUT and is compared every cycle; directed sections pin the model with
// hand-computed values.
module tb_sseg_scan_ctrl;

    localparam int N_DIG    = 3;
    localparam int PRESCALE = 16;
    localparam int FRAME    = N_DIG * PRESCALE;

    // Active-low {a..g} codes for 0..F.
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        reset_n;
    logic [11:0] hex_in;
    logic [2:0]  dp_in;
    logic [2:0]  blank_in;
    logic [2:0]  bright;
    logic        load;
    logic        pending;
    logic        frame_tick;
    logic [2:0]  an;
    logic [7:0]  sseg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sseg_scan_ctrl #(.N_DIG(N_DIG), .PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .bright     (bright),
        .load       (load),
        .pending    (pending),
        .frame_tick (frame_tick),
        .an         (an),
        .sseg       (sseg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // t counts cycles since reset release; slot, digit and frame position
    // follow from plain division of t.
    typedef struct {
        int          t;
        logic        pend;
        logic [11:0] sh_hex, ac_hex;
        logic [2:0]  sh_dp, ac_dp, sh_blank, ac_blank, sh_br, ac_br;
        logic [2:0]  an;
        logic [7:0]  sseg;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.t = 0;        r.pend = 1'b0;
        r.sh_hex = '0;  r.ac_hex = '0;
        r.sh_dp = '0;   r.ac_dp = '0;
        r.sh_blank = '0; r.ac_blank = 3'b111;
        r.sh_br = '0;   r.ac_br = '0;
        r.an = 3'b111;  r.sseg = 8'hFF;
        return r;
    endfunction

`ifdef SSEG_LZ_BLANK_EN
    // Digit d>0 hidden when it and every digit above are zero with dp off.
    function automatic bit lz_hide(logic [11:0] h, logic [2:0] d, int dg);
        logic [11:0] s;
        if (dg == 0) return 1'b0;
        for (int j = dg; j < N_DIG; j++) begin
            s = h >> (4 * j);
            if (s[3:0] != 4'h0 || d[j]) return 1'b0;
        end
        return 1'b1;
    endfunction
`endif

    function automatic model_t model_step(model_t c, logic ld, logic [11:0] h,
                                          logic [2:0] d, logic [2:0] b, logic [2:0] br);
        model_t n;
        int slot, dg;
        bit boundary, dark, lz;
        logic [11:0] s;
        n        = c;
        slot     = c.t % PRESCALE;
        dg       = (c.t / PRESCALE) % N_DIG;
        boundary = (c.t % FRAME) == FRAME - 1;
        s        = c.ac_hex >> (4 * dg);
`ifdef SSEG_LZ_BLANK_EN
        lz = lz_hide(c.ac_hex, c.ac_dp, dg);
`else
        lz = 1'b0;
`endif
        dark = c.ac_blank[dg] || lz || slot < 1 ||
               slot >= (int'(c.ac_br) + 1) * (PRESCALE / 8);
        if (dark) begin
            n.an   = 3'b111;
            n.sseg = 8'hFF;
        end else begin
            n.an   = ~(3'b001 << dg);
            n.sseg = {~c.ac_dp[dg], SEG_TAB[s[3:0]]};
        end
        if (boundary && c.pend) begin
            n.ac_hex = c.sh_hex; n.ac_dp = c.sh_dp;
            n.ac_blank = c.sh_blank; n.ac_br = c.sh_br;
        end
        if (ld) begin
            n.sh_hex = h; n.sh_dp = d; n.sh_blank = b; n.sh_br = br;
            n.pend = 1'b1;
        end else if (boundary) begin
            n.pend = 1'b0;
        end
        n.t = c.t + 1;
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= model_reset();
        else          m <= model_step(m, load, hex_in, dp_in, blank_in, bright);
    end

    // One compare process, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("an",         32'(an),         32'(m.an));
            check("sseg",       32'(sseg),       32'(m.sseg));
            check("pending",    32'(pending),    32'(m.pend));
            check("frame_tick", 32'(frame_tick), 32'((m.t % FRAME) == FRAME - 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_load(input logic [11:0] h, input logic [2:0] d,
                           input logic [2:0] b, input logic [2:0] br);
        hex_in = h; dp_in = d; blank_in = b; bright = br;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Returns at the negedge where frame_tick is high.
    task automatic wait_tick();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("frame_tick_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lit_cnt;
        hex_in = '0; dp_in = '0; blank_in = '0; bright = '0; load = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en  = 1'b1;
        reset_n = 1'b1;

        // Idle after reset: dark, nothing pending.
        repeat (200) @(negedge clk);
        check("idle_an",      32'(an),      32'h7);
        check("idle_sseg",    32'(sseg),    32'hFF);
        check("idle_pending", 32'(pending), 32'h0);

        // 3A5 at full brightness.
        wait_tick();
        @(negedge clk);
        do_load(12'h3A5, 3'b000, 3'b000, 3'd7);
        check("load_pending", 32'(pending), 32'h1);
        wait_tick();
        check("pend_at_tick", 32'(pending), 32'h1);
        @(negedge clk);
        check("pend_cleared", 32'(pending), 32'h0);
        @(negedge clk);
        check("dead_cycle_an", 32'(an), 32'h7);
        @(negedge clk);
        check("dig0_an",   32'(an),   32'h6);
        check("dig0_sseg", 32'(sseg), 32'hA4);
        repeat (PRESCALE) @(negedge clk);
        check("dig1_an",   32'(an),   32'h5);
        check("dig1_sseg", 32'(sseg), 32'h88);
        repeat (PRESCALE) @(negedge clk);
        check("dig2_an",   32'(an),   32'h3);
        check("dig2_sseg", 32'(sseg), 32'h86);

        // Brightness 0: one lit cycle per digit per frame.
        wait_tick();
        @(negedge clk);
        do_load(12'h3A5, 3'b000, 3'b000, 3'd0);
        wait_tick();
        @(negedge clk);
        lit_cnt = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (an !== 3'b111) lit_cnt++;
        end
        check("bright0_lit_cycles", 32'(lit_cnt), 32'd3);

        // Two loads in one frame: last wins.
        wait_tick();
        @(negedge clk);
        do_load(12'h111, 3'b000, 3'b000, 3'd7);
        repeat (5) @(negedge clk);
        do_load(12'h222, 3'b000, 3'b000, 3'd7);
        wait_tick();
        @(negedge clk);
        check("two_load_pend", 32'(pending), 32'h0);
        repeat (2) @(negedge clk);
        check("two_load_sseg", 32'(sseg), 32'h92);

        // Load on the boundary cycle: held for the following frame.
        wait_tick();
        do_load(12'h777, 3'b000, 3'b000, 3'd7);
        check("coincident_pend", 32'(pending), 32'h1);
        wait_tick();
        @(negedge clk);
        check("coincident_pend_clr", 32'(pending), 32'h0);
        repeat (2) @(negedge clk);
        check("coincident_sseg", 32'(sseg), 32'h8F);

        // Randomized loads, model-checked every cycle.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                hex_in   = 12'($urandom);
                dp_in    = 3'($urandom);
                blank_in = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
                bright   = 3'($urandom);
                load     = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;

        // Reset mid-slot with a pending shadow.
        wait_tick();
        @(negedge clk);
        do_load(12'hABC, 3'b000, 3'b000, 3'd7);
        repeat (5) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("rst_an",      32'(an),         32'h7);
        check("rst_sseg",    32'(sseg),       32'hFF);
        check("rst_pending", 32'(pending),    32'h0);
        check("rst_tick",    32'(frame_tick), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3 * FRAME) @(negedge clk);
        check("post_rst_an",      32'(an),      32'h7);
        check("post_rst_pending", 32'(pending), 32'h0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
